counter_mod: RTL and testbench

Parametrised, loadable up/down modulo counter; the generalised successor to the fixed 4-bit ripple-enable counter. It is built from a chain of bit-slice cells with carry/borrow propagation and adds a programmable modulus, direction control, synchronous load/clear, saturate or wrap mode, and terminal-count/overflow flags. It serves as the standard timebase and event counter for downstream timer and divider blocks.

---
 rtl/counter_pkg.sv | 13 +
 rtl/cnt_cell.sv | 37 +++
 rtl/counter_mod.sv | 98 +++++++++
 tb/tb_counter_mod.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Used by counter_mod and any timer/divider block that instantiates it.
package counter_pkg;

   localparam int unsigned CNT_WRAP = 0;
   localparam int unsigned CNT_SAT  = 1;

   // Limit a load value to the top of the count range.
   function automatic logic [31:0] clamp_max(input logic [31:0] value, input logic [31:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/cnt_cell.sv
// One bit slice of the counter: toggles on carry/borrow-in, or loads ldv when ld is high.
// ca ripples to the next slice: carry when counting up, borrow when counting down.
module cnt_cell (
   input  logic ck,
   input  logic res,
   input  logic en,
   input  logic up,
   input  logic ld,
   input  logic ldv,
   output logic q,
   output logic ca
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ldv;
      end else if (en) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge ck or negedge res) begin
      if (!res) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q  = q_q;
   assign ca = up ? (en & q_q) : (en & ~q_q);

endmodule

// File: rtl/counter_mod.sv
// Loadable up/down modulo counter built from a ripple chain of cnt_cell slices.
// The top level handles the range boundaries, clr/load priority and the wrap/ovf flags.
module counter_mod
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX      = 32'((64'd1 << WIDTH) - 64'd1),
   parameter int unsigned SATURATE = CNT_WRAP
) (
   input  logic             ck,
   input  logic             res,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

   logic             at_max;
   logic             at_zero;
   logic             cell_en;
   logic             cell_ld;
   logic [WIDTH-1:0] cell_ldv;
   logic [WIDTH:0]   carry;
   logic             unused_carry;

   logic wrap_q, wrap_d;
   logic ovf_q, ovf_d;

   // Boundary detection and control muxing. A boundary edge either reloads the
   // opposite end of the range (wrap) or suppresses the chain entirely (saturate).
   always_comb begin
      at_max   = (q == MAX_Q);
      at_zero  = (q == '0);
      tc       = en & ~clr & ~load & (up ? at_max : at_zero);
      cell_en  = en;
      cell_ld  = 1'b0;
      cell_ldv = '0;
      if (clr) begin
         cell_ld  = 1'b1;
         cell_ldv = '0;
      end else if (load) begin
         cell_ld  = 1'b1;
         cell_ldv = WIDTH'(clamp_max(32'(d), MAX));
      end else if (tc) begin
         if (SATURATE == CNT_SAT) begin
            cell_en = 1'b0;
         end else begin
            cell_ld  = 1'b1;
            cell_ldv = up ? '0 : MAX_Q;
         end
      end
   end

   assign carry[0] = cell_en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      cnt_cell u_cell (
         .ck  (ck),
         .res (res),
         .en  (carry[i]),
         .up  (up),
         .ld  (cell_ld),
         .ldv (cell_ldv[i]),
         .q   (q[i]),
         .ca  (carry[i+1])
      );
   end

   // The top slice's carry-out only matters to a wider chain.
   assign unused_carry = carry[WIDTH];

   // tc is already masked by clr and load, so it alone marks a boundary event.
   always_comb begin
      wrap_d = tc;
      ovf_d  = clr ? 1'b0 : (ovf_q | tc);
   end

   always_ff @(posedge ck or negedge res) begin
      if (!res) begin
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign wrap = wrap_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: a wrapping and a saturating instance (WIDTH=4, MAX=9)
// share stimulus and are compared against an arithmetic reference model.
module tb_counter_mod;

   localparam int unsigned W = 4;
   localparam int unsigned M = 9;

   logic         ck = 1'b0;
   logic         res;
   logic         clr;
   logic         load;
   logic [W-1:0] d;
   logic         en;
   logic         up;

   logic [W-1:0] q_w, q_s;
   logic         tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

   int checks   = 0;
   int failures = 0;

   // Reference state: index 0 = wrap instance, 1 = saturate instance.
   int mq[2];
   bit mwrap[2];
   bit movf[2];

   always #5 ck = ~ck;

   counter_mod #(.WIDTH(W), .MAX(M), .SATURATE(0)) u_wrap (
      .ck(ck), .res(res), .clr(clr), .load(load), .d(d), .en(en), .up(up),
      .q(q_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
   );

   counter_mod #(.WIDTH(W), .MAX(M), .SATURATE(1)) u_sat (
      .ck(ck), .res(res), .clr(clr), .load(load), .d(d), .en(en), .up(up),
      .q(q_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_tc(input int k);
      if (!en || clr || load) return 1'b0;
      return up ? (mq[k] == int'(M)) : (mq[k] == 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k]    = 0;
         mwrap[k] = 1'b0;
         movf[k]  = 1'b0;
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, " q_wrap"},    32'(q_w),    32'(mq[0]));
      chk({tag, " wrap_wrap"}, 32'(wrap_w), 32'(mwrap[0]));
      chk({tag, " ovf_wrap"},  32'(ovf_w),  32'(movf[0]));
      chk({tag, " q_sat"},     32'(q_s),    32'(mq[1]));
      chk({tag, " wrap_sat"},  32'(wrap_s), 32'(mwrap[1]));
      chk({tag, " ovf_sat"},   32'(ovf_s),  32'(movf[1]));
   endtask

   task automatic check_tc(input string tag);
      chk({tag, " tc_wrap"}, 32'(tc_w), 32'(model_tc(0)));
      chk({tag, " tc_sat"},  32'(tc_s), 32'(model_tc(1)));
   endtask

   // Entered just after a rising edge; applies inputs, checks tc, clocks one edge,
   // advances the model and checks the registered outputs.
   task automatic step(input string tag, input bit c, input bit l, input int dv,
                       input bit e, input bit u);
      bit b;
      clr  = c;
      load = l;
      d    = W'(dv);
      en   = e;
      up   = u;
      #1;
      check_tc(tag);
      for (int k = 0; k < 2; k++) begin
         b = model_tc(k);
         if (c) begin
            mq[k]    = 0;
            mwrap[k] = 1'b0;
            movf[k]  = 1'b0;
         end else if (l) begin
            mq[k]    = (dv > int'(M)) ? int'(M) : dv;
            mwrap[k] = 1'b0;
         end else if (e) begin
            if (u) mq[k] = (mq[k] < int'(M)) ? mq[k] + 1 : ((k == 1) ? int'(M) : 0);
            else   mq[k] = (mq[k] > 0) ? mq[k] - 1 : ((k == 1) ? 0 : int'(M));
            mwrap[k] = b;
            if (b) movf[k] = 1'b1;
         end else begin
            mwrap[k] = 1'b0;
         end
      end
      @(posedge ck);
      #1;
      check_regs(tag);
   endtask

   initial begin
      res  = 1'b0;
      clr  = 1'b0;
      load = 1'b0;
      d    = '0;
      en   = 1'b1;
      up   = 1'b1;
      model_reset();

      // Reset state, tc for both directions.
      #2;
      check_regs("reset");
      check_tc("reset_up");
      chk("reset tc_up", 32'(tc_w), 32'd0);
      up = 1'b0;
      #1;
      chk("reset tc_down", 32'(tc_w), 32'd1);
      @(posedge ck);
      #1;
      check_regs("reset_edge");
      res = 1'b1;

      // Count up through the wrap.
      for (int i = 0; i < 10; i++) step("up_run", 0, 0, 0, 1, 1);
      chk("up_run end q", 32'(q_w), 32'd0);
      chk("up_run end wrap", 32'(wrap_w), 32'd1);
      chk("up_run end ovf", 32'(ovf_w), 32'd1);

      // Load 3 then count down through zero.
      step("load3", 0, 1, 3, 0, 1);
      for (int i = 0; i < 4; i++) step("down_run", 0, 0, 0, 1, 0);
      chk("down_run end q", 32'(q_w), 32'd9);
      chk("down_run end wrap", 32'(wrap_w), 32'd1);

      // Saturation at MAX: wrap pulses on each held edge.
      step("load8", 0, 1, 8, 0, 1);
      for (int i = 0; i < 3; i++) step("sat_run", 0, 0, 0, 1, 1);
      chk("sat_run end q", 32'(q_s), 32'd9);
      chk("sat_run end wrap", 32'(wrap_s), 32'd1);
      chk("sat_run end ovf", 32'(ovf_s), 32'd1);

      // Load clamp and clr priority.
      step("load15", 0, 1, 15, 0, 1);
      chk("load15 clamp", 32'(q_w), 32'd9);
      step("clr_prio", 1, 1, 5, 1, 1);
      chk("clr_prio q", 32'(q_w), 32'd0);
      chk("clr_prio ovf", 32'(ovf_s), 32'd0);

      // Enable gaps and direction change.
      step("load2", 0, 1, 2, 0, 1);
      step("en1", 0, 0, 0, 1, 1);
      step("en0", 0, 0, 0, 0, 1);
      step("en1b", 0, 0, 0, 1, 1);
      chk("en_toggle q", 32'(q_w), 32'd4);
      step("load5", 0, 1, 5, 0, 1);
      step("dir_up", 0, 0, 0, 1, 1);
      step("dir_down", 0, 0, 0, 1, 0);
      chk("dir_flip q", 32'(q_w), 32'd5);

      // Reach q=7 with ovf set, then reset asynchronously between edges.
      step("load8b", 0, 1, 8, 0, 1);
      for (int i = 0; i < 9; i++) step("to7", 0, 0, 0, 1, 1);
      chk("pre_reset q", 32'(q_w), 32'd7);
      #3;
      res = 1'b0;
      model_reset();
      #1;
      check_regs("async_reset");
      chk("async_reset q", 32'(q_w), 32'd0);
      @(posedge ck);
      #1;
      check_regs("reset_hold");
      res = 1'b1;
      step("resume", 0, 0, 0, 1, 1);
      chk("resume q", 32'(q_w), 32'd1);

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(15) == 0), ($urandom_range(7) == 0),
              int'($urandom_range(15)), ($urandom_range(3) != 0), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
